// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: controller/memory-facing bundle of the fetch sequencer
interface fetch_sequencer_if #(
  parameter int AWIDTH  = 5,
  parameter int OPWIDTH = 3,
  parameter int CNTW    = 16
);
  localparam int DWIDTH = OPWIDTH + AWIDTH;
  logic               go;
  logic               halt;
  logic               ld_ir;
  logic               inc_pc;
  logic               ld_pc;
  logic               sel;
  logic [DWIDTH-1:0]  data_in;
  logic [2:0]         phase;
  logic [OPWIDTH-1:0] opcode;
  logic [AWIDTH-1:0]  ir_addr;
  logic [AWIDTH-1:0]  pc_addr;
  logic [AWIDTH-1:0]  addr;
  logic               running;
  logic [CNTW-1:0]    instr_cnt;
  modport master (
    output go, halt, ld_ir, inc_pc, ld_pc, sel, data_in,
    input  phase, opcode, ir_addr, pc_addr, addr, running, instr_cnt
  );
  modport slave (
    input  go, halt, ld_ir, inc_pc, ld_pc, sel, data_in,
    output phase, opcode, ir_addr, pc_addr, addr, running, instr_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: phase counter, IR and PC with RUN/HALTED control and retired-instruction count
module fetch_sequencer #(
  parameter int AWIDTH  = 5,
  parameter int OPWIDTH = 3,
  parameter int CNTW    = 16
) (
  input logic clk,
  input logic rst,
  fetch_sequencer_if.slave bus
);
  localparam int DWIDTH = OPWIDTH + AWIDTH;
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;
  logic [0:0]        state;
  logic [2:0]        phase;
  logic [DWIDTH-1:0] ir;
  logic [AWIDTH-1:0] pc;
  logic [CNTW-1:0]   cnt;
  // a HALT retires on its halt edge, every other instruction on the 7->0 wrap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      phase <= '0;
      ir    <= '0;
      pc    <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      state <= bus.halt ? HALTED : RUN;
      phase <= bus.halt ? phase : phase + 3'd1;
      if ((bus.halt || phase == 3'd7) && cnt != '1) cnt <= cnt + 1'b1;
      if (bus.ld_ir) ir <= bus.data_in;
      if (bus.ld_pc) pc <= ir[AWIDTH-1:0];
      else if (bus.inc_pc) pc <= pc + 1'b1;
    end else if (bus.go) begin
      state <= RUN;
      phase <= '0;
    end
  assign bus.phase     = phase;
  assign bus.opcode    = ir[DWIDTH-1 -: OPWIDTH];
  assign bus.ir_addr   = ir[AWIDTH-1:0];
  assign bus.pc_addr   = pc;
  assign bus.addr      = bus.sel ? pc : ir[AWIDTH-1:0];
  assign bus.running   = state == RUN;
  assign bus.instr_cnt = cnt;
endmodule
